// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the parity helper.
// The receive path imports this package as well.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 10416;  // 100 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period down-counter for the UART transmitter. It pulses bit_done_o for one cycle
// when the count reaches 0, then reloads. It is held at the reload value while run_i is low.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int CNT_W        = 14
) (
  input  logic clk_in,
  input  logic rst,
  input  logic run_i,
  output logic bit_done_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT >= (1 << CNT_W)) begin : g_bad_cfg
    $error("uart_tx_bit_timer: CLKS_PER_BIT out of range for CNT_W");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done_o = run_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (!run_i || bit_done_o) cnt_d = RELOAD;
  end

  always_ff @(posedge clk_in) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter (8N1 by default; define UART_TX_PARITY_EN for an 8-bit + parity frame).
// It takes one byte per valid/ready handshake and shifts it out LSB-first on tx_serial.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 14,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_transmitter: PARITY_ODD must be 0 or 1");
  end

  uart_state_e            state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic                   tx_serial_q, ready_q, busy_q;
  logic                   bit_done;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  uart_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk_in     (clk_in),
    .rst        (rst),
    .run_i      (state_q != IDLE),
    .bit_done_o (bit_done)
  );

  // tx_serial is driven from the current state, so the line lags a state change by one
  // edge. ready/busy are updated on the transition edge itself.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_serial_q <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_serial_q <= 1'b1;
          if (tx_valid && ready_q) begin
            shift_q   <= tx_data;
            bit_idx_q <= '0;
            state_q   <= START;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= parity_bit(tx_data, PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          tx_serial_q <= 1'b0;
          if (bit_done) state_q <= DATA;
        end
        DATA: begin
          tx_serial_q <= shift_q[0];
          if (bit_done) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_serial_q <= par_q;
          if (bit_done) state_q <= STOP;
        end
`endif
        STOP: begin
          tx_serial_q <= 1'b1;
          if (bit_done) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          tx_serial_q <= 1'b1;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_ready  = ready_q;
  assign tx_busy   = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised self-checking bench for uart_transmitter. A line-level decoder and a handshake
// monitor feed a byte scoreboard, and one frame is checked cycle by cycle.
module tb_uart_transmitter;

  localparam int C     = 16;
  localparam int P_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_serial, tx_busy;

  uart_transmitter #(
    .CLKS_PER_BIT (C),
    .CNT_W        (5),
    .PARITY_ODD   (P_ODD)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int n_sent = 0, n_hs = 0, n_rx = 0, pair_bad = 0;
  logic [7:0] exp_q[$];
  int hs_q[$];
  int st_log[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference frame: start 0, data LSB-first, [parity], stop 1; index 0 goes out first.
  function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    logic p;
    p = (^b) ^ (P_ODD != 0);
    return {1'b1, p, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // A transfer happens at the next posedge whenever valid && ready hold at a negedge.
  initial forever begin
    @(negedge clk_in);
    if (!rst) begin
      if (tx_ready == tx_busy) pair_bad++;
      if (tx_valid && tx_ready) begin
        n_hs++;
        hs_q.push_back(cyc + 1);
        exp_q.push_back(tx_data);
      end
    end
  end

  task automatic wait_n(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk_in);
      if (rst) ab = 1'b1;
    end
  endtask

  // Line decoder samples each bit at its centre. A frame cut short by reset is dropped.
  initial begin : decoder
    logic       prev;
    logic [7:0] d;
    logic       sb;
    logic [7:0] eb;
    int         st, eh;
    bit         ab;
`ifdef UART_TX_PARITY_EN
    logic       pb;
`endif
    prev = 1'b1;
    forever begin
      @(negedge clk_in);
      if (!rst && prev && !tx_serial) begin
        st = cyc;
        ab = 1'b0;
        wait_n(C / 2, ab);
        if (!ab) chk("start_bit", tx_serial, 0);
        for (int i = 0; i < 8; i++) begin
          wait_n(C, ab);
          d[i] = tx_serial;
        end
`ifdef UART_TX_PARITY_EN
        wait_n(C, ab);
        pb = tx_serial;
`endif
        wait_n(C, ab);
        sb = tx_serial;
        if (ab) begin
          if (exp_q.size() > 0) eb = exp_q.pop_front();
          if (hs_q.size() > 0) eh = hs_q.pop_front();
        end else begin
          n_rx++;
          st_log.push_back(st);
          if (exp_q.size() == 0) chk("extra_frame", 1, 0);
          else begin
            eb = exp_q.pop_front();
            eh = hs_q.pop_front();
            chk("rx_byte", d, eb);
            chk("start_lat", st, eh + 1);
`ifdef UART_TX_PARITY_EN
            chk("parity", pb, (^eb) ^ (P_ODD != 0));
`endif
          end
          chk("stop_bit", sb, 1);
        end
      end
      prev = tx_serial;
    end
  end

  task automatic send(input logic [7:0] b, output int hs);
    int t;
    t = 0;
    @(posedge clk_in); #1;
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk_in);
    while (!tx_ready && t < 20 * C) begin
      @(negedge clk_in);
      t++;
    end
    if (!tx_ready) chk("send_timeout", 0, 1);
    hs = cyc + 1;
    @(posedge clk_in); #1;
    tx_valid = 1'b0;
    n_sent++;
  endtask

  task automatic wait_rx(input int target);
    int t;
    t = 0;
    while (n_rx < target && t < 30 * C) begin
      @(negedge clk_in);
      t++;
    end
    if (n_rx < target) chk("rx_timeout", n_rx, target);
  endtask

  initial begin
    int hs, bad, ok, n, t;
    int h[2];
    logic [NB-1:0] fr;

    repeat (3) @(posedge clk_in);
    #1 rst = 1'b0;
    @(negedge clk_in);
    chk("rst_serial", tx_serial, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    bad = 0;
    repeat (200) begin
      @(negedge clk_in);
      if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("idle_hold", bad, 0);

    // Cycle-exact single frame
    send(8'hA5, hs);
    fr = frame_of(8'hA5);
    @(negedge clk_in);
    chk("hs_serial", tx_serial, 1);
    chk("hs_ready", tx_ready, 0);
    chk("hs_busy", tx_busy, 1);
    for (int k = 0; k < NB; k++) begin
      ok = 0;
      for (int j = 0; j < C; j++) begin
        @(negedge clk_in);
        if (tx_serial == fr[k]) ok++;
        if (k == NB - 1 && j == C - 2) chk("ready_before_end", tx_ready, 0);
        if (k == NB - 1 && j == C - 1) chk("ready_at_end", tx_ready, 1);
      end
      chk($sformatf("bit%0d_hold", k), ok, C);
    end

    // Random bytes with random idle gaps
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk_in);
      send(8'($urandom), hs);
    end
    wait_rx(n_sent);

    // Back-to-back transfers with tx_valid held high
    @(posedge clk_in); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    n = 0;
    t = 0;
    while (n < 2 && t < 40 * C) begin
      @(negedge clk_in);
      t++;
      if (tx_ready) begin
        h[n] = cyc + 1;
        @(posedge clk_in); #1;
        n++;
        if (n == 1) tx_data = 8'hFF;
        else tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    if (n < 2) chk("b2b_timeout", n, 2);
    n_sent += n;
    chk("b2b_hs_gap", h[1] - h[0], NB * C + 1);
    wait_rx(n_sent);
    if (st_log.size() >= 2)
      chk("b2b_start_gap", st_log[st_log.size()-1] - st_log[st_log.size()-2], NB * C + 1);

    // tx_valid mid-frame while not ready must be ignored
    send(8'hC3, hs);
    repeat (3 * C) @(posedge clk_in);
    #1;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    repeat (5) @(posedge clk_in);
    #1 tx_valid = 1'b0;
    wait_rx(n_sent);

    // Reset during data bit 4 of 0x81, then a clean frame
    send(8'h81, hs);
    repeat (5 * C + C / 2) @(posedge clk_in);
    @(negedge clk_in);
    chk("pre_rst_line", tx_serial, 0);
    @(posedge clk_in); #1 rst = 1'b1;
    @(posedge clk_in); #1 rst = 1'b0;
    @(negedge clk_in);
    chk("abort_serial", tx_serial, 1);
    chk("abort_ready", tx_ready, 1);
    chk("abort_busy", tx_busy, 0);
    repeat (12 * C) @(posedge clk_in);
    send(8'h55, hs);
`ifdef UART_TX_PARITY_EN
    send(8'h07, hs);
`endif
    wait_rx(n_sent - 1);
    repeat (2 * C) @(posedge clk_in);

    chk("rx_count", n_rx, n_sent - 1);
    chk("hs_count", n_hs, n_sent);
    chk("exp_left", exp_q.size(), 0);
    chk("ready_busy_pair", pair_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
